// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice bank.
// Holds the command opcodes, the i_data field layout, the top-octave
// phase-increment table, the per-note increment helper and the
// saturating clamp used on the summed sample.
package synth_pkg;

  typedef enum logic [1:0] {
    OP_IDLE   = 2'b00,
    OP_ON     = 2'b01,
    OP_OFF    = 2'b10,
    OP_ALLOFF = 2'b11
  } opcode_t;

  // i_data layout: [15:14] opcode, [13:7] note, [6:0] velocity
  localparam int OP_LSB   = 14;
  localparam int OP_W     = 2;
  localparam int NOTE_LSB = 7;
  localparam int NOTE_W   = 7;
  localparam int VEL_LSB  = 0;
  localparam int VEL_W    = 7;

  // Signed top 16 phase bits times a 8-bit non-negative velocity
  localparam int SAMPLE_W = 24;

  // Increments for notes 120..131 at a 48 kHz sample rate and a 32-bit
  // accumulator; lower octaves are these values shifted right.
  localparam logic [31:0] NOTE_INC_TABLE [12] = '{
    32'd749115498,  32'd793660223,  32'd840853716,  32'd890853480,
    32'd943826385,  32'd999949222,  32'd1059409297, 32'd1122405052,
    32'd1189146729, 32'd1259857073, 32'd1334772074, 32'd1414141751
  };

  function automatic logic [31:0] note_inc(input logic [NOTE_W-1:0] note);
    logic [3:0] oct;
    logic [3:0] semi;
    oct  = 4'(note / 7'd12);
    semi = 4'(note % 7'd12);
    return NOTE_INC_TABLE[semi] >> (4'd10 - oct);
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement word
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/bank_voice.sv
// One sawtooth voice of the bank.
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   load                  start/retrigger: take note/velocity/increment, phase 0
//   clear                 release: free the voice and zero its phase
//   advance               sample strobe: busy voice steps its phase by inc
//   load_note/vel/inc     values captured on load
//   busy, note            current allocation state
//   sample                signed(phase top 16 bits) * velocity, 0 when free
module bank_voice
  import synth_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       load,
  input  logic                       clear,
  input  logic                       advance,
  input  logic [NOTE_W-1:0]          load_note,
  input  logic [VEL_W-1:0]           load_vel,
  input  logic [PHASE_W-1:0]         load_inc,
  output logic                       busy,
  output logic [NOTE_W-1:0]          note,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic [VEL_W-1:0]   vel;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc;

  // A command on the same edge as a strobe wins over the phase advance
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      busy  <= 1'b0;
      note  <= '0;
      vel   <= '0;
      phase <= '0;
      inc   <= '0;
    end else if (load) begin
      busy  <= 1'b1;
      note  <= load_note;
      vel   <= load_vel;
      inc   <= load_inc;
      phase <= '0;
    end else if (clear) begin
      busy  <= 1'b0;
      phase <= '0;
    end else if (advance && busy) begin
      phase <= phase + inc;
    end
  end

  logic signed [15:0]    phase_hi;
  logic signed [VEL_W:0] vel_s;

  assign phase_hi = phase[PHASE_W-1 -: 16];
  assign vel_s    = {1'b0, vel};
  assign sample   = busy ? SAMPLE_W'(phase_hi) * SAMPLE_W'(vel_s) : '0;

endmodule

// File: rtl/bank_manager.sv
// Polyphonic sawtooth voice bank.
// Decodes one-shot note commands, allocates them over NVOICES voices
// (retrigger same note, else lowest free voice, else round-robin steal),
// and sums the voice samples into a saturated signed output per strobe.
// Ports:
//   clk, n_rst   clock, synchronous active-low reset
//   clk_en       sample strobe; phases advance and o_signal updates only then
//   i_data       command word {opcode[1:0], note[6:0], velocity[6:0]}, 0 = idle
//   o_signal     registered saturated sum of all voices (signed)
//   o_active     per-voice busy flags
module bank_manager
  import synth_pkg::*;
#(
  parameter int NVOICES = 4,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 24
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clk_en,
  input  logic [15:0]        i_data,
  output logic [OUT_W-1:0]   o_signal,
  output logic [NVOICES-1:0] o_active
);

  localparam int IDX_W = $clog2(NVOICES);
  localparam int SUM_W = OUT_W + IDX_W;

  opcode_t           op;
  logic [NOTE_W-1:0] cmd_note;
  logic [VEL_W-1:0]  cmd_vel;
  logic              note_on;
  logic              note_off;
  logic              all_off;

  assign op       = opcode_t'(i_data[OP_LSB +: OP_W]);
  assign cmd_note = i_data[NOTE_LSB +: NOTE_W];
  assign cmd_vel  = i_data[VEL_LSB +: VEL_W];
  // A zero-velocity note-on is a release
  assign note_on  = (op == OP_ON) && (cmd_vel != '0);
  assign note_off = (op == OP_OFF) || ((op == OP_ON) && (cmd_vel == '0));
  assign all_off  = (op == OP_ALLOFF);

  logic [NVOICES-1:0]          busy;
  logic [NVOICES-1:0]          match;
  logic [NVOICES-1:0]          load;
  logic [NVOICES-1:0]          clear;
  logic [NOTE_W-1:0]           voice_note [NVOICES];
  logic signed [SAMPLE_W-1:0]  sample     [NVOICES];
  logic [PHASE_W-1:0]          voice_inc;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            free_idx;
  logic                        free_found;
  logic                        steal;

  assign voice_inc = PHASE_W'(note_inc(cmd_note));

  always_comb begin
    for (int i = 0; i < NVOICES; i++) begin
      match[i] = busy[i] && (voice_note[i] == cmd_note);
    end
  end

  // Allocator: retrigger wins over a free voice, which wins over stealing
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    load  = '0;
    clear = '0;
    steal = 1'b0;
    if (note_on) begin
      if (|match) begin
        load = match;
      end else if (free_found) begin
        load[free_idx] = 1'b1;
      end else begin
        load[rr_ptr] = 1'b1;
        steal        = 1'b1;
      end
    end else if (note_off) begin
      clear = match;
    end else if (all_off) begin
      clear = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr_ptr <= '0;
    end else if (steal) begin
      rr_ptr <= rr_ptr + IDX_W'(1);
    end
  end

  for (genvar v = 0; v < NVOICES; v++) begin : g_voice
    bank_voice #(
      .PHASE_W(PHASE_W)
    ) u_voice (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (load[v]),
      .clear    (clear[v]),
      .advance  (clk_en),
      .load_note(cmd_note),
      .load_vel (cmd_vel),
      .load_inc (voice_inc),
      .busy     (busy[v]),
      .note     (voice_note[v]),
      .sample   (sample[v])
    );
  end

  // ---- p0: full-width sum of pre-edge voice samples, then clamp ----
  logic signed [SUM_W-1:0] sum_p0;
  logic [OUT_W-1:0]        sat_p0;

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < NVOICES; i++) begin
      sum_p0 = sum_p0 + SUM_W'(sample[i]);
    end
  end

  assign sat_p0 = OUT_W'(saturate(32'(sum_p0), OUT_W));

  // ---- p1: registered output sample ----
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_signal <= '0;
    end else if (clk_en) begin
      o_signal <= sat_p0;
    end
  end

  assign o_active = busy;

endmodule

// File: tb/tb_bank_manager.sv
module tb_bank_manager;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clk_en;
  logic [15:0]   i_data;
  logic [23:0]   o_signal;
  logic [NV-1:0] o_active;

  bank_manager #(
    .NVOICES(NV),
    .PHASE_W(32),
    .OUT_W  (24)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .clk_en  (clk_en),
    .i_data  (i_data),
    .o_signal(o_signal),
    .o_active(o_active)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint    tbl [12];
  bit        m_busy  [NV];
  int        m_note  [NV];
  int        m_vel   [NV];
  bit [31:0] m_phase [NV];
  bit [31:0] m_inc   [NV];
  bit        m_touch [NV];
  int        m_ptr;
  longint    m_sig;
  int        m_act;
  bit        m_valid = 0;
  int        mop, mnt, mvl, midx, mph;
  longint    msum;

  function automatic bit [31:0] inc_of(input int note);
    return 32'(tbl[note % 12] >> (10 - note / 12));
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      for (int v = 0; v < NV; v++) begin
        m_busy[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_phase[v] = 0; m_inc[v] = 0;
      end
      m_ptr = 0;
      m_sig = 0;
    end else begin
      mop = int'(i_data[15:14]);
      mnt = int'(i_data[13:7]);
      mvl = int'(i_data[6:0]);
      if (clk_en) begin
        msum = 0;
        for (int v = 0; v < NV; v++) begin
          if (m_busy[v]) begin
            mph = int'(m_phase[v] >> 16);
            if (mph >= 32768) mph -= 65536;
            msum += longint'(mph) * m_vel[v];
          end
        end
        m_sig = (msum > 8388607) ? 8388607 : (msum < -8388608) ? -8388608 : msum;
      end
      for (int v = 0; v < NV; v++) m_touch[v] = 0;
      if (mop == 1 && mvl != 0) begin
        midx = -1;
        for (int v = 0; v < NV; v++)
          if (m_busy[v] && m_note[v] == mnt) midx = v;
        if (midx < 0)
          for (int v = 0; v < NV; v++)
            if (!m_busy[v] && midx < 0) midx = v;
        if (midx < 0) begin
          midx  = m_ptr;
          m_ptr = (m_ptr + 1) % NV;
        end
        m_busy[midx] = 1; m_note[midx] = mnt; m_vel[midx] = mvl;
        m_inc[midx] = inc_of(mnt); m_phase[midx] = 0; m_touch[midx] = 1;
      end else if (mop == 1 || mop == 2) begin
        for (int v = 0; v < NV; v++)
          if (m_busy[v] && m_note[v] == mnt) begin
            m_busy[v] = 0; m_phase[v] = 0; m_touch[v] = 1;
          end
      end else if (mop == 3) begin
        for (int v = 0; v < NV; v++) begin
          m_busy[v] = 0; m_phase[v] = 0; m_touch[v] = 1;
        end
      end
      if (clk_en)
        for (int v = 0; v < NV; v++)
          if (m_busy[v] && !m_touch[v]) m_phase[v] = m_phase[v] + m_inc[v];
    end
    m_act = 0;
    for (int v = 0; v < NV; v++) if (m_busy[v]) m_act |= (1 << v);
    m_valid = 1;
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("o_signal", $signed(o_signal), m_sig);
      check("o_active", o_active, m_act);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [15:0] d, input logic en);
    i_data = d;
    clk_en = en;
    @(negedge clk);
  endtask

  function automatic logic [15:0] on_cmd(input int note, input int vel);
    return {2'b01, 7'(note), 7'(vel)};
  endfunction

  function automatic logic [15:0] off_cmd(input int note);
    return {2'b10, 7'(note), 7'd0};
  endfunction

  int sat_hi, sat_lo, r;
  int notes4 [4] = '{60, 62, 64, 65};

  initial begin
    for (int k = 0; k < 12; k++)
      tbl[k] = longint'(440.0 * 2.0 ** ((51 + k) / 12.0) * 4294967296.0 / 48000.0);

    // reset with a live command and strobe present
    n_rst  = 1'b0;
    clk_en = 1'b1;
    i_data = 16'h62FF;
    @(negedge clk);
    @(negedge clk);
    check("reset_signal", $signed(o_signal), 0);
    check("reset_active", o_active, 0);
    n_rst = 1'b1;
    repeat (5) step(16'h0000, 1'($urandom_range(0, 1)));
    check("idle_active", o_active, 0);
    check("idle_signal", $signed(o_signal), 0);

    // single note 69 vel 127, loaded while clk_en is low
    step(16'h62FF, 1'b0);
    check("single_active", o_active, 4'b0001);
    step(16'h0000, 1'b1);
    check("first_sample", $signed(o_signal), 0);
    step(16'h0000, 1'b1);
    check("second_sample", $signed(o_signal), 76200);
    repeat (3) step(16'h0000, 1'b0);
    check("hold_sample", $signed(o_signal), 76200);

    // releases
    step(16'hA280, 1'b0);
    check("off_active", o_active, 4'b0000);
    step(16'h0000, 1'b1);
    check("off_sample", $signed(o_signal), 0);
    step(on_cmd(60, 100), 1'b0);
    step(off_cmd(61), 1'b1);
    check("off_miss_active", o_active, 4'b0001);
    step(16'hC000, 1'b0);
    check("alloff_one", o_active, 4'b0000);

    // allocation, stealing, retrigger
    for (int i = 0; i < 4; i++) step(on_cmd(notes4[i], 90 + i), 1'($urandom_range(0, 1)));
    check("alloc_full", o_active, 4'b1111);
    step(on_cmd(67, 127), 1'b1);
    step(on_cmd(69, 127), 1'b1);
    step(on_cmd(64, 50), 1'b1);
    step(off_cmd(67), 1'b0);
    check("steal_v0", o_active, 4'b1110);
    step(off_cmd(69), 1'b0);
    check("steal_v1", o_active, 4'b1100);
    step(on_cmd(70, 80), 1'b1);
    check("refill_v0", o_active, 4'b1101);
    step(16'hC000, 1'b1);
    check("alloff_four", o_active, 4'b0000);

    // four in-phase loud voices drive the sum into both rails
    for (int n = 96; n < 100; n++) step(on_cmd(n, 127), 1'b0);
    sat_hi = 0;
    sat_lo = 0;
    repeat (300) begin
      step(16'h0000, 1'b1);
      if (o_signal == 24'h7FFFFF) sat_hi = 1;
      if (o_signal == 24'h800000) sat_lo = 1;
    end
    check("sat_hi_seen", sat_hi, 1);
    check("sat_lo_seen", sat_lo, 1);

    // note-on coincident with the strobe
    step(16'hC000, 1'b0);
    step(16'h62FF, 1'b1);
    check("sim_edge", $signed(o_signal), 0);
    step(16'h0000, 1'b1);
    check("sim_phase0", $signed(o_signal), 0);
    step(16'h0000, 1'b1);
    check("sim_next", $signed(o_signal), 76200);

    // randomized traffic
    repeat (2000) begin
      r = $urandom_range(0, 99);
      if (r < 8)
        i_data = on_cmd($urandom_range(0, 127), ($urandom_range(0, 3) == 0) ?
                        $urandom_range(0, 127) : $urandom_range(100, 127));
      else if (r < 12)
        i_data = off_cmd(m_note[$urandom_range(0, NV - 1)]);
      else if (r < 13)
        i_data = 16'hC000;
      else if (r < 15)
        i_data = on_cmd(m_note[$urandom_range(0, NV - 1)], $urandom_range(1, 127));
      else
        i_data = 16'h0000;
      step(i_data, 1'($urandom_range(0, 9) < 7));
    end

    // reset overrides a concurrent command and strobe
    step(on_cmd(50, 60), 1'b1);
    n_rst = 1'b0;
    step(16'h62FF, 1'b1);
    check("rst_override_active", o_active, 0);
    check("rst_override_signal", $signed(o_signal), 0);
    n_rst = 1'b1;
    step(16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bank_manager.md
Name: bank_manager

Overview:
- Polyphonic voice bank for the synthesizer. Sits between the Avalon command register and the mixer.
- Decodes one-shot 16-bit note commands and allocates them to NVOICES sawtooth voices.
- Each voice is a phase-accumulator sawtooth scaled by its velocity.
- Produces one saturated signed 24-bit summed sample per clk_en cycle.

Parameters:
- NVOICES, 4, number of simultaneous voices (power of two, 2..8).
- PHASE_W, 32, phase accumulator width.
- OUT_W, 24, output sample width.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- clk_en  in  1  sample strobe: advance phases and update o_signal only when high.
- i_data  in  16  one-shot command word. Value 0 means idle.
- o_signal  out  24  signed summed sample, registered.
- o_active  out  NVOICES  per-voice busy flags, registered.

Behaviour:
- Reset (n_rst=0 at a clk edge): all voices free, all phases 0, velocities 0, round-robin pointer 0, o_signal=0, o_active=0. Reset overrides everything else.
- Command decode:
  - [15:14] opcode: 00 idle, 01 note-on, 10 note-off, 11 all-off.
  - [13:7] note (0..127).
  - [6:0] velocity.
- Commands are honoured on every clk edge regardless of clk_en, so a single-cycle pulse is never lost.
- Note-on with velocity 0 is treated as note-off.
- Note-on:
  - If a busy voice already holds the same note, retrigger it: phase <= 0, velocity updated.
  - Else take the lowest-index free voice: busy, note, velocity, inc, phase <= 0.
  - If all voices are busy, steal the voice at the round-robin pointer, then increment the pointer modulo NVOICES.
- Note-off: free every busy voice holding that note (busy <= 0, phase <= 0). If none match, no effect.
- All-off: free all voices and zero their phases. The pointer is unchanged.
- Phase increment:
  - oct = note/12, semi = note%12.
  - inc = NOTE_INC_TABLE[semi] >> (10 - oct).
  - Table entry k = round(f(120+k) * 2^32 / 48000), where f(n) = 440 * 2^((n-69)/12).
  - Computed once at allocation and stored per voice.
- Sample cycle (clk_en=1), using the voice state held before this edge:
  - Voice sample = signed(phase[31:16]) * {1'b0, velocity}, giving a 24-bit signed product. A free voice contributes 0.
  - Sum all voices at full width (OUT_W + clog2(NVOICES) bits).
  - Saturate to [-8388608, 8388607]; register into o_signal.
  - Busy voices then do phase <= phase + inc, with modulo-2^32 wrap.
- Latency: o_signal reflects the phases before the advancing edge and appears one clk after the clk_en edge.
- clk_en=0: o_signal and all phases hold.
- Command and clk_en on the same edge:
  - o_signal uses the pre-command state.
  - A voice the command touches takes the command result (phase 0), not the advance.
- o_active mirrors the busy flags after each edge.

Decomposition:
- Package synth_pkg holds:
  - opcode enum: OP_IDLE, OP_ON, OP_OFF, OP_ALLOFF.
  - NOTE_INC_TABLE, 12 x 32-bit.
  - field positions and widths of i_data.
  - saturate function.
- Sub-module bank_voice, instantiated NVOICES times. It holds busy/note/velocity/phase/inc and provides:
  - load, clear and advance controls.
  - the scaled sample output.
- bank_manager contains the decoder, allocator, round-robin pointer, adder tree and saturation.

Test Plan:
- Reset: hold n_rst=0 for 2 clk with clk_en=1 and i_data=0x62FF -> o_signal=0, o_active=0. After release, the bank stays idle until a command arrives.
- Single note: i_data=0x62FF for one cycle (note 69, vel 127), clk_en=0, then strobe clk_en:
  - o_active=0001.
  - First sample is 0.
  - Second sample = signed((TABLE[9]>>5)[31:16]) * 127.
  - o_signal holds between strobes.
- Note-off / all-off: 0xA280 frees voice 0 (o_active=0000, next sample 0). Note-off for a note not playing has no effect. 0xC000 clears 4 busy voices at once.
- Allocation and stealing: note-on notes 60, 62, 64, 65 -> o_active=1111. Note 67 steals voice 0 (pointer -> 1); note 69 steals voice 1. Re-sending note 64 retriggers voice 2 with phase 0.
- Saturation: run 4 voices at vel 127 and compare every sample to a reference model of clamp(sum) -> o_signal never wraps and hits 0x7FFFFF/0x800000 at extremes. Also check phase wrap at 2^32.
- Simultaneous events: note-on coincident with clk_en -> that edge's o_signal excludes the new voice, and its phase is 0 afterwards. A command arriving while clk_en=0 is still applied.
